alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational datapath ALU. Accepts one operation per transaction on a valid/ready input, produces a registered result with full Z/N/C/V flags on a valid/ready output, and adds signed shift, rotate and inc/dec. An optional multi-cycle shift-add multiplier is included. Sits between the register-file read ports and the write-back mux of the datapath.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_mul_seq.sv | 62 ++++++
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state type and the
// registered flag bundle.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h7;
    localparam logic [OP_W-1:0] OP_SRA  = 4'h8;
    localparam logic [OP_W-1:0] OP_MUL  = 4'h9;
    localparam logic [OP_W-1:0] OP_ROL  = 4'hA;
    localparam logic [OP_W-1:0] OP_PASA = 4'hB;
    localparam logic [OP_W-1:0] OP_PASB = 4'hC;
    localparam logic [OP_W-1:0] OP_INC  = 4'hD;
    localparam logic [OP_W-1:0] OP_DEC  = 4'hE;
    localparam logic [OP_W-1:0] OP_ILL  = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic err;
    } alu_flags_t;

    // Flags matching a zero result after reset.
    localparam alu_flags_t FLAGS_RST = '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0};

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per clock, LSB first.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load operands and begin WIDTH iterations
//   a, b          multiplicand, multiplier (sampled when start is high)
//   busy          iteration in progress (counter nonzero)
//   done          the coming edge performs the final iteration
//   product       accumulator value after the coming edge; valid with done
// done/product look one step ahead so the consumer can register the final
// product on the very edge that finishes the last iteration.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;

    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    assign busy    = (r_cnt != '0);
    assign done    = (r_cnt == CNT_W'(1));
    assign product = w_acc_next;

    // Operand load on start, then one add/shift step per cycle while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (busy) begin
            r_cnt    <= r_cnt - CNT_W'(1);
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and Z/N/C/V/err flags.
// Optional macro ALU_SEQ_MUL_EN builds the multi-cycle multiplier (op 9);
// without it op 9 is decoded as illegal.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_ready    operation handshake
//   op, a, b              opcode and operands
//   out_valid, out_ready  result handshake
//   y                     registered result
//   z, n, c, v            zero, negative, carry, signed overflow
//   err                   illegal opcode for the held result
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  y,
    output logic              z,
    output logic              n,
    output logic              c,
    output logic              v,
    output logic              err
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned SHW1 = SHW + 1;
    localparam int unsigned W1   = WIDTH + 1;
    localparam int unsigned MSB  = WIDTH - 1;

    logic [WIDTH-1:0] r_y;
    alu_flags_t       r_flags;
    logic             r_out_valid;

    logic             w_accept;
    logic [SHW-1:0]   w_amt;
    logic [SHW:0]     w_ramt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH:0]   w_sra;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_res_y;
    alu_flags_t       w_res_flags;

    assign w_amt  = b[SHW-1:0];
    assign w_ramt = SHW1'(WIDTH) - {1'b0, w_amt};

    // Extended forms keep the carry / last shifted-out bit in the extra bit.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_inc  = {1'b0, a} + W1'(1);
    assign w_dec  = {1'b0, a} - W1'(1);
    assign w_shl  = {1'b0, a} << w_amt;
    assign w_shr  = {a, 1'b0} >> w_amt;
    assign w_sra  = $signed({a, 1'b0}) >>> w_amt;
    // Amount 0 gives a shift-right by WIDTH, which contributes zero.
    assign w_rol  = (a << w_amt) | (a >> w_ramt);

    // Single-cycle result and flags; borrow-style ops report c = no borrow.
    always_comb begin
        w_res_y         = a;
        w_res_flags     = '0;
        case (op)
            OP_ADD: begin
                w_res_y       = w_sum[MSB:0];
                w_res_flags.c = w_sum[WIDTH];
                w_res_flags.v = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_res_y       = w_diff[MSB:0];
                w_res_flags.c = ~w_diff[WIDTH];
                w_res_flags.v = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            OP_AND:  w_res_y = a & b;
            OP_OR:   w_res_y = a | b;
            OP_XOR:  w_res_y = a ^ b;
            OP_NOT:  w_res_y = ~a;
            OP_SHL: begin
                w_res_y       = w_shl[MSB:0];
                w_res_flags.c = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res_y       = w_shr[WIDTH:1];
                w_res_flags.c = w_shr[0];
            end
            OP_SRA: begin
                w_res_y       = w_sra[WIDTH:1];
                w_res_flags.c = w_sra[0];
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  w_res_y = a;
`endif
            OP_ROL:  w_res_y = w_rol;
            OP_PASA: w_res_y = a;
            OP_PASB: w_res_y = b;
            OP_INC: begin
                w_res_y       = w_inc[MSB:0];
                w_res_flags.c = w_inc[WIDTH];
                w_res_flags.v = ~a[MSB] && w_inc[MSB];
            end
            OP_DEC: begin
                w_res_y       = w_dec[MSB:0];
                w_res_flags.c = ~w_dec[WIDTH];
                w_res_flags.v = a[MSB] && ~w_dec[MSB];
            end
            default: begin
                w_res_y         = a;
                w_res_flags.err = 1'b1;
            end
        endcase
        w_res_flags.z = (w_res_y == '0);
        w_res_flags.n = w_res_y[MSB];
    end

`ifdef ALU_SEQ_MUL_EN
    alu_state_t         r_state;
    logic               w_is_mul;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;
    logic [WIDTH-1:0]   w_mul_y;
    alu_flags_t         w_mul_flags;

    assign w_is_mul = (op == OP_MUL);

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_accept && w_is_mul),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    // Low half is the result; any set upper bit reports as carry.
    assign w_mul_y           = w_mul_product[MSB:0];
    assign w_mul_flags.z     = (w_mul_y == '0);
    assign w_mul_flags.n     = w_mul_y[MSB];
    assign w_mul_flags.c     = |w_mul_product[2*WIDTH-1:WIDTH];
    assign w_mul_flags.v     = 1'b0;
    assign w_mul_flags.err   = 1'b0;

    assign in_ready = (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
`else
    assign in_ready = !r_out_valid || out_ready;
`endif

    assign w_accept = in_valid && in_ready;

    // Output register and FSM; a new accept in the consume cycle keeps out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= '0;
            r_flags     <= FLAGS_RST;
            r_out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_state     <= ST_IDLE;
`endif
        end else begin
`ifdef ALU_SEQ_MUL_EN
            if (r_state == ST_MUL) begin
                if (w_mul_done) begin
                    r_y         <= w_mul_y;
                    r_flags     <= w_mul_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            end else if (w_accept && w_is_mul) begin
                r_out_valid <= 1'b0;
                r_state     <= ST_MUL;
            end else
`endif
            if (w_accept) begin
                r_y         <= w_res_y;
                r_flags     <= w_res_flags;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign z         = r_flags.z;
    assign n         = r_flags.n;
    assign c         = r_flags.c;
    assign v         = r_flags.v;
    assign err       = r_flags.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 16).
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  y;
    logic              z, n, c, v, err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic [4:0]       f;   // {z, n, c, v, err}
    } vec_t;

    vec_t vecs[23];

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one op for one edge; returns 1 time unit after that edge.
    task automatic send(input logic [3:0] o, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = xa;
        b        = xb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 5'b01010};
        vecs[1]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 5'b10100};
        vecs[2]  = '{OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 5'b01000};
        vecs[3]  = '{OP_SUB,  16'h1234, 16'h1234, 16'h0000, 5'b10100};
        vecs[4]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 5'b00110};
        vecs[5]  = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000};
        vecs[6]  = '{OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 5'b01000};
        vecs[7]  = '{OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 5'b10000};
        vecs[8]  = '{OP_NOT,  16'h00FF, 16'h0000, 16'hFF00, 5'b01000};
        vecs[9]  = '{OP_SHL,  16'h8001, 16'h0001, 16'h0002, 5'b00100};
        vecs[10] = '{OP_SHL,  16'h8001, 16'h0000, 16'h8001, 5'b01000};
        vecs[11] = '{OP_SHR,  16'h0018, 16'h0004, 16'h0001, 5'b00100};
        vecs[12] = '{OP_SRA,  16'h8010, 16'h0004, 16'hF801, 5'b01000};
        vecs[13] = '{OP_SRA,  16'h8008, 16'h0004, 16'hF800, 5'b01100};
        vecs[14] = '{OP_SHL,  16'h0001, 16'h0011, 16'h0002, 5'b00000};
        vecs[15] = '{OP_ROL,  16'h8001, 16'h0004, 16'h0018, 5'b00000};
        vecs[16] = '{OP_PASA, 16'h1234, 16'h5678, 16'h1234, 5'b00000};
        vecs[17] = '{OP_PASB, 16'h1234, 16'h8000, 16'h8000, 5'b01000};
        vecs[18] = '{OP_INC,  16'h7FFF, 16'h0000, 16'h8000, 5'b01010};
        vecs[19] = '{OP_INC,  16'hFFFF, 16'h0000, 16'h0000, 5'b10100};
        vecs[20] = '{OP_DEC,  16'h0000, 16'h0000, 16'hFFFF, 5'b01000};
        vecs[21] = '{OP_DEC,  16'h8000, 16'h0000, 16'h7FFF, 5'b00110};
        vecs[22] = '{OP_ILL,  16'hABCD, 16'h0001, 16'hABCD, 5'b01001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",      32'(y), 32'h0);
        chk("rst_flags",  32'({z, n, c, v, err}), 32'b10000);
        chk("rst_ovalid", 32'(out_valid), 32'h0);
        chk("rst_iready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back vectors with out_ready high: one result per cycle.
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_y", i),      32'(y), 32'(vecs[i].y));
            chk($sformatf("vec%0d_flags", i),  32'({z, n, c, v, err}), 32'(vecs[i].f));
            chk($sformatf("vec%0d_ovalid", i), 32'(out_valid), 32'h1);
            chk($sformatf("vec%0d_iready", i), 32'(in_ready), 32'h1);
        end

        // Stall: result held and no acceptance while out_ready is low.
        send(OP_ADD, 16'h0001, 16'h0002);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op       = OP_SUB;
            a        = 16'h0009;
            b        = 16'h0001;
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_y", i),      32'(y), 32'h0003);
            chk($sformatf("stall%0d_ovalid", i), 32'(out_valid), 32'h1);
            chk($sformatf("stall%0d_iready", i), 32'(in_ready), 32'h0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_ovalid", 32'(out_valid), 32'h0);
        chk("drain_iready", 32'(in_ready), 32'h1);
        chk("drain_y",      32'(y), 32'h0003);

        // Asynchronous reset mid-stream, checked before any clock edge.
        send(OP_ADD, 16'h7FFF, 16'h0001);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_y",      32'(y), 32'h0);
        chk("arst_flags",  32'({z, n, c, v, err}), 32'b10000);
        chk("arst_ovalid", 32'(out_valid), 32'h0);
        chk("arst_iready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

`ifdef ALU_SEQ_MUL_EN
        // MUL 0x0100 * 0x0100 = 0x1_0000: low half zero, carry set.
        send(OP_MUL, 16'h0100, 16'h0100);
        chk("mul0_iready_k", 32'(in_ready), 32'h0);
        chk("mul0_ovalid_k", 32'(out_valid), 32'h0);
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mul0_busy%0d", i), 32'({out_valid, in_ready}), 32'b00);
        end
        @(posedge clk);
        #1;
        chk("mul0_ovalid", 32'(out_valid), 32'h1);
        chk("mul0_y",      32'(y), 32'h0000);
        chk("mul0_flags",  32'({z, n, c, v, err}), 32'b10100);

        send(OP_MUL, 16'h00FF, 16'h0003);
        repeat (WIDTH) @(posedge clk);
        #1;
        chk("mul1_y",     32'(y), 32'h02FD);
        chk("mul1_flags", 32'({z, n, c, v, err}), 32'b00000);

        send(OP_MUL, 16'hFFFF, 16'hFFFF);
        repeat (WIDTH) @(posedge clk);
        #1;
        chk("mul2_y",     32'(y), 32'h0001);
        chk("mul2_flags", 32'({z, n, c, v, err}), 32'b00100);

        // Reset five edges into an iteration: no partial result ever shows.
        send(OP_MUL, 16'h0100, 16'h0100);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mulrst_ovalid", 32'(out_valid), 32'h0);
        chk("mulrst_iready", 32'(in_ready), 32'h1);
        chk("mulrst_y",      32'(y), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mulrst_quiet%0d", i), 32'(out_valid), 32'h0);
        end
`else
        // Without the multiplier op 9 is illegal: y = a, err = 1.
        send(OP_MUL, 16'h5555, 16'h0002);
        chk("mul_off_y",      32'(y), 32'h5555);
        chk("mul_off_flags",  32'({z, n, c, v, err}), 32'b00001);
        chk("mul_off_ovalid", 32'(out_valid), 32'h1);
        chk("mul_off_iready", 32'(in_ready), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
